nonce_report_queue: RTL and testbench
=====================================

Name: nonce_report_queue

Overview:
Downstream of the SHA-256 miner core. Captures each golden nonce flagged by the core's got_ticket output into a small FIFO. Drains entries as a byte stream over a valid/ready handshake to the UART transmitter, so closely spaced hits are not lost while the host link is slow.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
PTR_W, 2, log2(DEPTH); must match DEPTH.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-low
got_ticket  input  1  hit flag from miner core; may stay high for more than one cycle
golden_nonce  input  32  nonce from miner core; valid while got_ticket is high
ovf_clear  input  1  synchronous pulse; clears the sticky overflow flag
tx_data  output  8  byte to transmitter
tx_valid  output  1  tx_data is valid
tx_ready  input  1  transmitter accepts the byte this cycle
fifo_count  output  PTR_W+1  entries currently stored
overflow  output  1  sticky: at least one nonce was dropped

Behaviour:
- Reset (rst low, asynchronous): FSM to IDLE; FIFO empty; pointers 0; got_ticket edge register 0.
- Reset output values: tx_data=0, tx_valid=0, fifo_count=0, overflow=0.
- Reset asserted mid-transfer aborts the byte stream immediately. Stored entries are lost.
- Capture:
  - A push occurs on the cycle where got_ticket=1 and the registered got_ticket from the previous cycle is 0 (rising edge).
  - golden_nonce is sampled that same cycle.
  - Each rising edge produces exactly one push.
- Push when full:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the nonce is dropped and overflow is set to 1 on the next cycle.
- overflow clears only on ovf_clear=1. If ovf_clear and a drop happen in the same cycle, the set wins.
- fifo_count is registered. On simultaneous push and pop the count is unchanged.
- Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if fifo_count>0, pop the head entry into a 32-bit shift register, byte index = 0, go to SEND. tx_valid=0.
  - SEND: tx_valid=1; tx_data = shift register byte (byte index) — little-endian, byte 0 = golden_nonce[7:0].
    - On tx_valid&&tx_ready: index+1.
    - After byte 3 is accepted, go to IDLE.
- Handshake:
  - tx_data is held stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops before acceptance.
  - A 1-cycle IDLE gap between nonces is required.
- Latency: rising edge of got_ticket in cycle N; fifo_count=1 in N+1; pop in N+1; tx_valid=1 with byte 0 in N+2 (if FIFO was empty and FSM was in IDLE).
- A pop reads from FIFO memory, not through a write bypass. An entry written in cycle N is poppable at N+1 at the earliest.

Optional Feature:
NONCE_REPORT_HEADER_EN
- Defined:
  - SEND is preceded by state HDR, which emits sync byte 8'hAA with the same handshake rules.
  - Each report is 5 bytes.
  - Latency to the first byte is unchanged: 8'hAA appears at N+2.
- Undefined: HDR state and its logic are absent; 4-byte reports.

Decomposition:
- Shared package nonce_report_pkg holds:
  - FSM state encoding (IDLE, HDR, SEND)
  - NONCE_W=32, BYTE_W=8, SYNC_BYTE=8'hAA
- One sub-module: nonce_fifo (DEPTH x 32 storage, pointers, count, full/empty).
- FSM and serializer stay in the top.

Test Plan:
- Reset, then got_ticket pulse with golden_nonce=32'h12345678, tx_ready=1 → tx_data sequence 78,56,34,12 on cycles N+2..N+5; fifo_count back to 0; overflow=0.
- got_ticket held high 10 cycles, nonce=32'hDEADBEEF → exactly one report EF,BE,AD,DE.
- tx_ready=0, then 5 separate got_ticket pulses (nonces 1..5) with DEPTH=4:
  - fifo_count=3 after the first pop, reaches 4.
  - overflow=1 after the 5th pulse only if the FIFO is full at that time.
  - Release tx_ready → the stored nonces are emitted in order.
  - ovf_clear → overflow=0.
- tx_ready toggling 1/0 every cycle → tx_data stable during stalls; no byte duplicated or skipped.
- Assert rst mid-report (after byte 1) with 2 entries queued → tx_valid=0 and fifo_count=0 immediately; no further bytes after rst is released.
- With NONCE_REPORT_HEADER_EN: nonce 32'h00000001 → AA,01,00,00,00.

Source files
------------

// File: rtl/nonce_report_pkg.sv
// Shared types and constants for the nonce report queue.
// Holds the serializer FSM encoding and the nonce/byte geometry.
package nonce_report_pkg;

    localparam int NONCE_W         = 32;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_NONCE = NONCE_W / BYTE_W;
    localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hAA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

endpackage

// File: rtl/nonce_fifo.sv
// Purpose: DEPTH x 32-bit nonce FIFO with registered count and full/empty flags.
// Latency: an entry written in cycle N is visible at the head from cycle N+1 (no write bypass).
// Backpressure: a push when full is refused unless a pop happens in the same cycle.
module nonce_fifo
    import nonce_report_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [NONCE_W-1:0] wdata,
    input  logic               pop,
    output logic [NONCE_W-1:0] rdata,
    output logic [PTR_W:0]     count,
    output logic               full,
    output logic               empty,
    output logic               push_ok
);

    logic [NONCE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // When full, the simultaneous pop frees the slot the push overwrites.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nonce_report_queue.sv
// Purpose: queue golden nonces from the miner and stream them as bytes (LSB first) to the UART; NONCE_REPORT_HEADER_EN adds a 0xAA sync byte.
// Latency: got_ticket rising edge in cycle N gives the first byte with tx_valid in cycle N+2.
// Backpressure: tx_valid/tx_data hold until tx_ready; a full FIFO without a same-cycle pop drops the nonce and sets overflow.
module nonce_report_queue
    import nonce_report_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               got_ticket,
    input  logic [NONCE_W-1:0] golden_nonce,
    input  logic               ovf_clear,
    output logic [BYTE_W-1:0]  tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [PTR_W:0]     fifo_count,
    output logic               overflow
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_NONCE - 1);

    state_t             state;
    state_t             state_nxt;
    logic               got_ticket_q;
    logic               push;
    logic               push_ok;
    logic               pop;
    logic               full;
    logic               empty;
    logic [NONCE_W-1:0] head;
    logic [NONCE_W-1:0] shreg;
    logic [1:0]         byte_idx;

    assign push = got_ticket && !got_ticket_q;

    nonce_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wdata   (golden_nonce),
        .pop     (pop),
        .rdata   (head),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty),
        .push_ok (push_ok)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
`ifdef NONCE_REPORT_HEADER_EN
                    state_nxt = ST_HDR;
`else
                    state_nxt = ST_SEND;
`endif
                end
            end
`ifdef NONCE_REPORT_HEADER_EN
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) begin
                    state_nxt = ST_SEND;
                end
            end
`endif
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = shreg[BYTE_W-1:0];
                if (tx_ready && byte_idx == LAST_IDX) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            got_ticket_q <= 1'b0;
            shreg        <= '0;
            byte_idx     <= '0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_nxt;
            got_ticket_q <= got_ticket;
            // A drop in the same cycle as ovf_clear keeps the flag set.
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
            if (pop) begin
                shreg    <= head;
                byte_idx <= '0;
            end else if (state == ST_SEND && tx_ready) begin
                shreg    <= shreg >> BYTE_W;
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nonce_report_queue.sv
// Directed bench for nonce_report_queue: a scoreboard of expected bytes is filled when nonces are driven
// and drained by a negedge monitor that also checks the valid/ready hold rule.
module tb_nonce_report_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic         clk;
    logic         rst;
    logic         got_ticket;
    logic [31:0]  golden_nonce;
    logic         ovf_clear;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [PTR_W:0] fifo_count;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    logic [7:0] exp_q[$];
    logic       prev_vld = 1'b0;
    logic       prev_rdy = 1'b0;
    logic [7:0] prev_dat = '0;

    nonce_report_queue #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .got_ticket   (got_ticket),
        .golden_nonce (golden_nonce),
        .ovf_clear    (ovf_clear),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic queue_nonce(input logic [31:0] n);
`ifdef NONCE_REPORT_HEADER_EN
        exp_q.push_back(8'hAA);
`endif
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(n[8*i +: 8]);
        end
    endtask

    // Drives a one-cycle got_ticket pulse; returns just after the capturing edge.
    task automatic pulse(input logic [31:0] n, input bit accept);
        golden_nonce = n;
        got_ticket   = 1'b1;
        if (accept) queue_nonce(n);
        step();
        got_ticket = 1'b0;
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // Byte acceptance happens at the following posedge; inputs are stable at the negedge.
    always @(negedge clk) begin
        if (!rst) begin
            prev_vld = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            if (prev_vld && !prev_rdy) begin
                checks++;
                assert (tx_valid === 1'b1 && tx_data === prev_dat) else begin
                    errors++;
                    $error("FAIL hold: observed vld=%0b dat=%0h expected vld=1 dat=%0h", tx_valid, tx_data, prev_dat);
                end
            end
            if (tx_valid && tx_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_byte: observed %0h expected none", tx_data);
                end
                if (exp_q.size() != 0) begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    checks++;
                    assert (tx_data === e) else begin
                        errors++;
                        $error("FAIL byte: observed %0h expected %0h", tx_data, e);
                    end
                end
                acc_cnt++;
            end
            prev_vld = tx_valid;
            prev_rdy = tx_ready;
            prev_dat = tx_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int base;
        int exp_cnt[5];
        logic [7:0] first_byte;
        exp_cnt = '{1, 1, 2, 3, 4};

        rst = 1'b0; got_ticket = 1'b0; golden_nonce = '0; ovf_clear = 1'b0; tx_ready = 1'b0;
        repeat (3) step();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b1;
        repeat (2) step();

        // Single nonce, latency and byte order.
        tx_ready = 1'b1;
        golden_nonce = 32'h12345678;
        got_ticket = 1'b1;
        queue_nonce(32'h12345678);
        step();
        got_ticket = 1'b0;
        chk("lat_count_n1", fifo_count, 1);
        chk("lat_valid_n1", tx_valid, 0);
        step();
`ifdef NONCE_REPORT_HEADER_EN
        first_byte = 8'hAA;
`else
        first_byte = 8'h78;
`endif
        chk("lat_valid_n2", tx_valid, 1);
        chk("lat_data_n2", tx_data, first_byte);
        chk("lat_count_n2", fifo_count, 0);
        drain(20, "drain_single");
        step();
        chk("single_count", fifo_count, 0);
        chk("single_overflow", overflow, 0);

        // Level-held ticket yields one report.
        golden_nonce = 32'hDEADBEEF;
        got_ticket = 1'b1;
        queue_nonce(32'hDEADBEEF);
        repeat (10) step();
        got_ticket = 1'b0;
        drain(30, "drain_held");
        repeat (10) step();
        chk("held_count", fifo_count, 0);

        // Fill with a stalled transmitter, then overflow.
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulse(32'(i + 1), 1'b1);
            chk("fill_count", fifo_count, exp_cnt[i]);
            step();
        end
        chk("fill_no_overflow", overflow, 0);
        pulse(32'd6, 1'b0);
        chk("drop_count", fifo_count, 4);
        chk("drop_overflow", overflow, 1);
        step();
        ovf_clear = 1'b1;
        pulse(32'd7, 1'b0);
        ovf_clear = 1'b0;
        chk("ovf_set_wins", overflow, 1);
        step();
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Push into a full FIFO on the same cycle as a pop is accepted.
        tx_ready = 1'b1;
        n = 0;
        while (!(tx_valid === 1'b0 && fifo_count == 4) && n < 30) begin
            step();
            n++;
        end
        chk("find_idle_full", n < 30, 1);
        golden_nonce = 32'h8;
        got_ticket = 1'b1;
        queue_nonce(32'h8);
        step();
        got_ticket = 1'b0;
        chk("full_pushpop_count", fifo_count, 4);
        chk("full_pushpop_overflow", overflow, 0);
        drain(80, "drain_full");
        step();
        chk("after_full_count", fifo_count, 0);

        // Ready toggling every cycle.
        pulse(32'hA1B2C3D4, 1'b1);
        step();
        pulse(32'h0F1E2D3C, 1'b1);
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tx_ready = ~tx_ready;
            step();
            n++;
        end
        chk("drain_toggle", exp_q.size(), 0);
        tx_ready = 1'b1;
        repeat (3) step();

        // Reset in the middle of a report with two entries queued.
        tx_ready = 1'b0;
        pulse(32'h11111111, 1'b1);
        step();
        pulse(32'h22222222, 1'b1);
        step();
        pulse(32'h33333333, 1'b1);
        step();
        chk("mid_queued", fifo_count, 2);
        base = acc_cnt;
        tx_ready = 1'b1;
        n = 0;
        while (acc_cnt < base + 2 && n < 20) begin
            step();
            n++;
        end
        chk("mid_two_bytes", acc_cnt - base, 2);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", tx_valid, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_data", tx_data, 0);
        exp_q.delete();
        repeat (2) step();
        rst = 1'b1;
        repeat (20) step();
        chk("mid_no_more_bytes", acc_cnt - base, 2);
        chk("mid_idle_valid", tx_valid, 0);

        // Small nonce; header byte leads when enabled.
        golden_nonce = 32'h00000001;
        got_ticket = 1'b1;
        queue_nonce(32'h00000001);
        step();
        got_ticket = 1'b0;
        step();
`ifdef NONCE_REPORT_HEADER_EN
        first_byte = 8'hAA;
`else
        first_byte = 8'h01;
`endif
        chk("one_first_byte", tx_data, first_byte);
        drain(20, "drain_one");
        step();
        chk("end_count", fifo_count, 0);
        chk("end_overflow", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
